// File: rtl/cic_out_stage.sv
// CIC output stage: drops post-reset settle samples, rounds/shifts/saturates
// the comb output to OW bits, and buffers it in a show-ahead FIFO.
module cic_out_stage #(
  parameter int IW     = 19,
  parameter int OW     = 16,
  parameter int SHIFT  = 3,
  parameter int DEPTH  = 8,
  parameter int SETTLE = 3
) (
  input  logic                    lr_clock,
  input  logic                    reset,
  input  logic signed [IW-1:0]    i_data,
  input  logic                    i_valid,
  output logic signed [OW-1:0]    o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_sat,
  output logic                    o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0]      SETTLE_INIT = SW'(SETTLE);
  localparam logic signed [IW:0] HALF = (IW+1)'((2 ** SHIFT) / 2);
  localparam logic signed [IW:0] MAXV = {{(IW+2-OW){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [IW:0] MINV = {{(IW+2-OW){1'b1}}, {(OW-1){1'b0}}};

  logic [SW-1:0]      settle_cnt;
  logic               settling;
  logic               accept;
  logic signed [IW:0] wide;
  logic signed [IW:0] rounded;
  logic signed [IW:0] shifted;
  logic               clip_hi;
  logic               clip_lo;
  logic [OW-1:0]      sat_val;
  logic               s1_valid;
  logic [OW-1:0]      s1_data;

  logic [OW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               full;
  logic               pop;
  logic               push_ok;

  assign settling = (settle_cnt != '0);
  assign accept   = i_valid && !settling;

  // One extra bit of headroom so the rounding add cannot wrap at full scale.
  always_comb begin
    wide    = {i_data[IW-1], i_data};
    rounded = wide + HALF;
    shifted = rounded >>> SHIFT;
    clip_hi = (shifted > MAXV);
    clip_lo = (shifted < MINV);
    if (clip_hi)
      sat_val = {1'b0, {(OW-1){1'b1}}};
    else if (clip_lo)
      sat_val = {1'b1, {(OW-1){1'b0}}};
    else
      sat_val = shifted[OW-1:0];
  end

  always_ff @(posedge lr_clock) begin
    if (reset) begin
      settle_cnt <= SETTLE_INIT;
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      o_sat      <= 1'b0;
    end else begin
      if (i_valid && settling)
        settle_cnt <= settle_cnt - 1'b1;
      s1_valid <= accept;
      if (accept)
        s1_data <= sat_val;
      o_sat <= accept && (clip_hi || clip_lo);
    end
  end

  assign full    = (o_count == (AW+1)'(DEPTH));
  assign o_valid = (o_count != '0);
  assign pop     = o_valid && i_ready;
  // A pop frees the head slot in the same edge, so a push into a full FIFO is legal.
  assign push_ok = s1_valid && (!full || pop);
  assign o_data  = o_valid ? $signed(mem[rd_ptr]) : '0;

  always_ff @(posedge lr_clock) begin
    if (push_ok)
      mem[wr_ptr] <= s1_data;
  end

  always_ff @(posedge lr_clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_count    <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
      if (s1_valid && full && !pop)
        o_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cic_out_stage.sv
// Bench for cic_out_stage: vector table for rounding/saturation, scoreboard
// on the FIFO output, and hand sequences for settle, full, wrap and reset.
module tb_cic_out_stage;

  logic               lr_clock = 1'b0;
  logic               reset;
  logic signed [18:0] i_data;
  logic               i_valid;
  logic signed [15:0] o_data;
  logic               o_valid;
  logic               i_ready;
  logic [3:0]         o_count;
  logic               o_sat;
  logic               o_overflow;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int sb_exp;

  typedef struct {
    logic signed [18:0] din;
    int                 exp_data;
    logic               exp_sat;
  } vec_t;

  vec_t vecs[13];

  cic_out_stage dut (
    .lr_clock   (lr_clock),
    .reset      (reset),
    .i_data     (i_data),
    .i_valid    (i_valid),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_sat      (o_sat),
    .o_overflow (o_overflow)
  );

  always #5 lr_clock = ~lr_clock;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge lr_clock);
    #1;
  endtask

  task automatic drive(input logic signed [18:0] d, input bit keep, input int exp);
    i_data  = d;
    i_valid = 1'b1;
    if (keep) exp_q.push_back(exp);
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_data  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic settle();
    for (int i = 0; i < 3; i++) begin
      drive(19'sh3ffff, 1'b0, 0);
      tick();
    end
    idle();
  endtask

  task automatic drain(input string name);
    int budget;
    i_ready = 1'b1;
    budget  = 0;
    while ((exp_q.size() != 0 || o_valid) && budget < 40) begin
      tick();
      budget++;
    end
    chk({name, "_left"}, exp_q.size(), 0);
    chk({name, "_valid"}, int'(o_valid), 0);
  endtask

  // Scoreboard: pop an expected word whenever the consumer takes the head.
  always @(negedge lr_clock) begin
    if (!reset && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL fifo_extra: got %0d expected no word", int'(o_data));
      end else begin
        sb_exp = exp_q.pop_front();
        chk("fifo_data", int'(o_data), sb_exp);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{19'sd12,      2,      1'b0};
    vecs[1]  = '{-19'sd12,     -1,     1'b0};
    vecs[2]  = '{19'sd7,       1,      1'b0};
    vecs[3]  = '{-19'sd5,      -1,     1'b0};
    vecs[4]  = '{19'sd262143,  32767,  1'b1};
    vecs[5]  = '{-19'sd262144, -32768, 1'b0};
    vecs[6]  = '{19'sd262139,  32767,  1'b0};
    vecs[7]  = '{19'sd262140,  32767,  1'b1};
    vecs[8]  = '{19'sd0,       0,      1'b0};
    vecs[9]  = '{19'sd3,       0,      1'b0};
    vecs[10] = '{19'sd4,       1,      1'b0};
    vecs[11] = '{-19'sd4,      0,      1'b0};
    vecs[12] = '{-19'sd20,     -2,     1'b0};

    reset   = 1'b1;
    i_ready = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_count", int'(o_count), 0);
    chk("rst_sat",   int'(o_sat), 0);
    chk("rst_ovf",   int'(o_overflow), 0);
    chk("rst_data",  int'(o_data), 0);
    reset = 1'b0;

    // Settle: samples 1..3 dropped, 4..6 each round to 1.
    for (int k = 1; k <= 6; k++) begin
      drive(19'(k), k > 3, 1);
      tick();
      chk("settle_valid", int'(o_valid), (k >= 5) ? 1 : 0);
    end
    idle();
    tick();
    chk("settle_count", int'(o_count), 3);
    drain("settle");

    // Rounding / saturation table, back to back.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].din, 1'b1, vecs[i].exp_data);
      tick();
      chk("vec_sat", int'(o_sat), int'(vecs[i].exp_sat));
    end
    idle();
    tick();
    chk("sat_clear", int'(o_sat), 0);
    drain("vec");

    // Full: 10 samples with consumer stalled, last two are lost.
    do_reset();
    settle();
    i_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      drive(19'(k * 8), k <= 8, k);
      tick();
    end
    idle();
    tick();
    tick();
    chk("full_count", int'(o_count), 8);
    chk("full_ovf",   int'(o_overflow), 1);
    chk("full_head",  int'(o_data), 1);
    drain("full");
    chk("ovf_sticky", int'(o_overflow), 1);

    // Full with simultaneous push/pop across pointer wrap.
    do_reset();
    settle();
    i_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      drive(19'(k * 8 + 800), 1'b1, k + 100);
      tick();
    end
    chk("pp_fill", int'(o_count), 8);
    i_ready = 1'b1;
    for (int k = 10; k <= 24; k++) begin
      drive(19'(k * 8 + 800), 1'b1, k + 100);
      tick();
      chk("pp_count", int'(o_count), 8);
      chk("pp_ovf",   int'(o_overflow), 0);
    end
    idle();
    drain("pp");

    // Reset with five words stored, then settle must repeat.
    do_reset();
    settle();
    i_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      drive(19'(k * 8), 1'b1, k);
      tick();
    end
    idle();
    tick();
    chk("pre_rst_count", int'(o_count), 5);
    do_reset();
    chk("mid_rst_valid", int'(o_valid), 0);
    chk("mid_rst_count", int'(o_count), 0);
    chk("mid_rst_ovf",   int'(o_overflow), 0);
    i_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive(19'(k * 80), k > 3, k * 10);
      tick();
    end
    idle();
    drain("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
